// File: rtl/product_accumulator.sv
// product_accumulator
//
// Sums frames of signed 64-bit products into a wide signed accumulator.
// A frame ends with an accepted product that has in_last set. The frame total,
// product count and a sticky overflow flag are then held until the consumer
// takes them.
//
// Build option:
//   PRODUCT_ACC_SAT_EN  defined   -> an overflowing add clamps the accumulator
//                                    to the signed max/min in the overflow direction
//                       undefined -> the accumulator wraps modulo 2^ACC_W
//   out_overflow is set on any overflowing add in both builds.
//
// Parameters:
//   ACC_W  accumulator / out_sum width, legal range 65..128
//   CNT_W  out_count width
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      product available
//   in_ready      block can take a product this cycle
//   in_product    signed product, two's complement
//   in_last       accepted product closes the frame
//   out_valid     frame result available
//   out_ready     consumer takes the result
//   out_sum       signed frame total
//   out_count     products in the frame, saturates at all-ones
//   out_overflow  sticky signed-overflow flag for the frame
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | empty frame, accumulator/count/flag cleared, accepting input
// ST_ACCUM | frame in progress, accepting input
// ST_HOLD  | frame complete, result presented, input stalled

module product_accumulator #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf;
   logic             ovf_nxt;

   logic             accept;
   logic             xfer;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum_raw;
   logic [ACC_W-1:0] sum_adj;
   logic             add_ovf;
   logic [CNT_W-1:0] cnt_inc;

   // ACC_W is at least 65, so the extension field is never empty.
   assign prod_ext = {{(ACC_W-64){in_product[63]}}, in_product};
   assign sum_raw  = acc + prod_ext;

   // Signed overflow: operands agree in sign but the result does not.
   assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef PRODUCT_ACC_SAT_EN
   // Overflow can only occur when both operands share a sign, so the
   // accumulator's sign gives the clamp direction.
   assign sum_adj  = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
   assign sum_adj  = sum_raw;
`endif

   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // in_ready is gated by rst so it reads low during the reset cycle itself.
   assign in_ready  = !rst && (state != ST_HOLD);
   assign out_valid = (state == ST_HOLD);
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   assign out_sum      = acc;
   assign out_count    = cnt;
   assign out_overflow = ovf;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      case (state)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               acc_nxt   = sum_adj;
               cnt_nxt   = cnt_inc;
               ovf_nxt   = ovf | add_ovf;
               state_nxt = in_last ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (xfer) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator. Two instances share one stimulus stream:
// a default-width one (ACC_W=72, CNT_W=16) and a narrow one (ACC_W=65,
// CNT_W=2) that reaches accumulator overflow and count saturation quickly.
// Expected results come from an arithmetic model of frame sums.

module tb_product_accumulator;

   localparam int AW_A = 72;
   localparam int CW_A = 16;
   localparam int AW_B = 65;
   localparam int CW_B = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic [63:0]     in_product = '0;
   logic            in_last = 1'b0;
   logic            out_ready = 1'b0;

   logic            in_ready_a, out_valid_a, out_overflow_a;
   logic [AW_A-1:0] out_sum_a;
   logic [CW_A-1:0] out_count_a;
   logic            in_ready_b, out_valid_b, out_overflow_b;
   logic [AW_B-1:0] out_sum_b;
   logic [CW_B-1:0] out_count_b;

   always #5 clk = ~clk;

   product_accumulator #(.ACC_W(AW_A), .CNT_W(CW_A)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_product(in_product), .in_last(in_last), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
      .out_overflow(out_overflow_a)
   );

   product_accumulator #(.ACC_W(AW_B), .CNT_W(CW_B)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_product(in_product), .in_last(in_last), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
      .out_overflow(out_overflow_b)
   );

   int nchecks = 0;
   int nfail   = 0;

   // Reference: exact running frame sum per instance, folded into range
   // after every add (clamp or modulo), plus count and sticky flag.
   logic signed [129:0] m_acc [2];
   int                  m_cnt [2];
   bit                  m_ovf [2];
   bit                  m_hold;
   int                  aw [2] = '{AW_A, AW_B};
   int                  cw [2] = '{CW_A, CW_B};

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nfail++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] lowbits(input logic signed [129:0] v, input int w);
      logic [129:0] m;
      logic [129:0] t;
      m = {130{1'b1}} >> (130 - w);
      t = v & m;
      return t[127:0];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = '0;
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
      end
      m_hold = 1'b0;
   endtask

   task automatic model_add(input int i, input logic [63:0] p);
      logic signed [63:0]  ps;
      logic signed [129:0] s, mx, mn, one, span;
      ps   = p;
      one  = 130'sd1;
      span = one <<< aw[i];
      mx   = (one <<< (aw[i] - 1)) - one;
      mn   = -(one <<< (aw[i] - 1));
      s    = m_acc[i] + ps;
      if (s > mx || s < mn) begin
         m_ovf[i] = 1'b1;
`ifdef PRODUCT_ACC_SAT_EN
         s = (s > mx) ? mx : mn;
`else
         s = (s > mx) ? s - span : s + span;
`endif
      end
      m_acc[i] = s;
      if (m_cnt[i] < (1 << cw[i]) - 1) m_cnt[i]++;
   endtask

   task automatic check_outputs();
      bit exp_rdy;
      exp_rdy = !m_hold && !rst;
      check_val("in_ready_a", 128'(in_ready_a), 128'(exp_rdy));
      check_val("in_ready_b", 128'(in_ready_b), 128'(exp_rdy));
      check_val("out_valid_a", 128'(out_valid_a), 128'(m_hold));
      check_val("out_valid_b", 128'(out_valid_b), 128'(m_hold));
      // Results are defined while holding, and are zero in a cleared idle.
      if (m_hold || m_cnt[0] == 0) begin
         check_val("sum_a", 128'(out_sum_a), lowbits(m_acc[0], AW_A));
         check_val("sum_b", 128'(out_sum_b), lowbits(m_acc[1], AW_B));
         check_val("count_a", 128'(out_count_a), 128'(m_cnt[0]));
         check_val("count_b", 128'(out_count_b), 128'(m_cnt[1]));
         check_val("ovf_a", 128'(out_overflow_a), 128'(m_ovf[0]));
         check_val("ovf_b", 128'(out_overflow_b), 128'(m_ovf[1]));
      end
   endtask

   // One cycle: check what the previous edge produced, then drive inputs for
   // the next edge and advance the model to the state after that edge.
   task automatic step(input bit r, input bit v, input logic [63:0] p, input bit l, input bit ordy);
      @(negedge clk);
      check_outputs();
      rst        = r;
      in_valid   = v;
      in_product = p;
      in_last    = l;
      out_ready  = ordy;
      if (r) begin
         clear_model();
      end else if (m_hold) begin
         if (ordy) clear_model();
      end else if (v) begin
         model_add(0, p);
         model_add(1, p);
         if (l) m_hold = 1'b1;
      end
   endtask

   function automatic logic [63:0] rand_prod();
      int     t;
      longint x;
      case ($urandom % 6)
         0: return 64'h7FFF_FFFF_FFFF_FFFF;
         1: return 64'h8000_0000_0000_0000;
         2: begin
            t = int'($urandom_range(0, 2000)) - 1000;
            x = t;
            return x;
         end
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      clear_model();

      // Reset, then single-product frame consumed on the first HOLD edge.
      step(1, 0, '0, 0, 0);
      step(1, 0, '0, 0, 0);
      step(0, 1, -64'sd5, 1, 1);
      step(0, 0, '0, 0, 1);
      check_val("single_valid", 128'(out_valid_a), 128'(1));
      check_val("single_sum", 128'(out_sum_a), lowbits(-130'sd5, AW_A));
      check_val("single_count", 128'(out_count_a), 128'(1));
      step(0, 0, '0, 0, 1);

      // Gapless 4-product frame.
      step(0, 1, 64'd3, 0, 1);
      step(0, 1, -64'sd7, 0, 1);
      step(0, 1, 64'd1000, 0, 1);
      step(0, 1, 64'h100_0000_0000, 1, 1);
      step(0, 0, '0, 0, 1);
      check_val("stream_sum", 128'(out_sum_a), lowbits((130'sd1 <<< 40) + 130'sd996, AW_A));
      check_val("stream_count", 128'(out_count_a), 128'(4));
      step(0, 0, '0, 0, 0);

      // Backpressure: result held while in_valid keeps toggling.
      step(0, 1, 64'd11, 0, 0);
      step(0, 1, 64'd22, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 1, rand_prod(), 1'($urandom % 2), 0);
      check_val("bp_sum", 128'(out_sum_a), lowbits(130'sd33, AW_A));
      step(0, 1, 64'd99, 1, 1);
      step(0, 0, '0, 0, 0);

      // Overflow on the 65-bit instance.
      for (int i = 0; i < 4; i++) step(0, 1, 64'h7FFF_FFFF_FFFF_FFFF, i == 3, 0);
      step(0, 0, '0, 0, 0);
      check_val("ovf_flag_b", 128'(out_overflow_b), 128'(1));
`ifdef PRODUCT_ACC_SAT_EN
      check_val("ovf_sum_b", 128'(out_sum_b), lowbits((130'sd1 <<< 64) - 130'sd1, AW_B));
`else
      check_val("ovf_sum_b", 128'(out_sum_b), lowbits(-130'sd4, AW_B));
`endif
      check_val("ovf_flag_a", 128'(out_overflow_a), 128'(0));
      step(0, 0, '0, 0, 1);
      step(0, 1, 64'd1, 1, 1);
      step(0, 0, '0, 0, 0);
      check_val("ovf_cleared_b", 128'(out_overflow_b), 128'(0));
      step(0, 0, '0, 0, 1);

      // Reset in the middle of a frame discards it.
      step(0, 1, 64'd10, 0, 0);
      step(0, 1, 64'd20, 0, 0);
      step(1, 0, '0, 0, 0);
      step(0, 1, 64'd7, 1, 0);
      step(0, 0, '0, 0, 0);
      check_val("rst_sum", 128'(out_sum_a), lowbits(130'sd7, AW_A));
      check_val("rst_count", 128'(out_count_a), 128'(1));
      step(0, 0, '0, 0, 1);

      // Count saturation on the CNT_W=2 instance.
      for (int i = 0; i < 5; i++) step(0, 1, 64'd1, i == 4, 0);
      step(0, 0, '0, 0, 0);
      check_val("sat_count_b", 128'(out_count_b), 128'(3));
      check_val("sat_sum_b", 128'(out_sum_b), lowbits(130'sd5, AW_B));
      check_val("sat_count_a", 128'(out_count_a), 128'(5));
      step(0, 0, '0, 0, 1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 200) == 0, ($urandom % 4) != 0, rand_prod(),
              ($urandom % 5) == 0, ($urandom % 2) == 0);
      end
      @(negedge clk);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
